// File: rtl/aes_pkg.sv
// AES shared definitions: GF(2^8) helpers, forward/inverse S-box, Rcon table,
// block constants and the iterative-decryptor FSM state.
package aes_pkg;
  localparam int AES_BLK_W = 128;
  localparam int AES_NR    = 10;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} aes_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = '0;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = gf_xtime(p);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse and maps 0 to 0, as the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Rcon table, valid for indices 1..10
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last is set. Byte n of the block sits at [127-8n -: 8].
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state,
  input  logic [AES_BLK_W-1:0] rk,
  input  logic                 last,
  output logic [AES_BLK_W-1:0] nxt
);
  logic [7:0]  x [16];
  logic [31:0] col;

  always_comb begin
    x   = '{default: 8'h00};
    col = '0;
    nxt = '0;
    // row r of column c comes from column (c-r) mod 4 before the shift
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        x[4*c+r] = inv_sbox(state[127-8*(4*((c+4-r)%4)+r) -: 8]) ^ rk[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++) begin
      col = {x[4*c], x[4*c+1], x[4*c+2], x[4*c+3]};
      nxt[127-32*c -: 32] = last ? col : inv_mix_col(col);
    end
  end
endmodule

// File: rtl/aes_inv_iter.sv
// Iterative AES-128 decryptor, LANES blocks in parallel under one key, one round
// per clock. Define AES_INV_KEY0_OUT_EN to expose the recovered cipher key on key0_out.
module aes_inv_iter
  import aes_pkg::*;
#(
  parameter int LANES = 1,
  parameter int NR    = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [AES_BLK_W*LANES-1:0]   ct_in,
  input  logic [AES_BLK_W-1:0]         key_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [AES_BLK_W*LANES-1:0]   pt_out
`ifdef AES_INV_KEY0_OUT_EN
  ,output logic [AES_BLK_W-1:0]        key0_out
`endif
);
  if (NR != AES_NR) begin : g_bad_nr
    $error("aes_inv_iter: NR must be %0d", AES_NR);
  end
  if (LANES < 1 || LANES > 4) begin : g_bad_lanes
    $error("aes_inv_iter: LANES must be 1..4");
  end

  aes_state_e                         st;
  logic [3:0]                         round;
  logic [LANES-1:0][AES_BLK_W-1:0]    lane_q, lane_nxt;
  logic [AES_BLK_W-1:0]               rk, rk_prev;
  logic [31:0]                        w0, w1, w2, w3, w3n;
  logic                               last;

  // Step the key schedule backwards one round; shared by every lane
  assign {w0, w1, w2, w3} = rk;
  assign w3n     = w3 ^ w2;
  assign rk_prev = {w0 ^ sub_word({w3n[23:0], w3n[31:24]}) ^ {rcon(round + 4'd1), 24'h0},
                    w1 ^ w0, w2 ^ w1, w3n};
  assign last    = (round == 4'd0);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_inv_round u_round (
      .state (lane_q[i]),
      .rk    (rk_prev),
      .last  (last),
      .nxt   (lane_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= IDLE;
      round  <= '0;
      lane_q <= '0;
      rk     <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          lane_q <= ct_in ^ {LANES{key_last}};
          rk     <= key_last;
          round  <= 4'(NR - 1);
          st     <= RUN;
        end
        RUN: begin
          lane_q <= lane_nxt;
          rk     <= rk_prev;
          if (last) st <= DONE;
          else      round <= round - 4'd1;
        end
        DONE: if (out_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign pt_out    = lane_q;
`ifdef AES_INV_KEY0_OUT_EN
  // after the final round rk has walked back to the cipher key
  assign key0_out  = rk;
`endif
endmodule

// File: tb/tb_aes_inv_iter.sv
// Scoreboard bench for aes_inv_iter (LANES=2): expectations come from a forward
// AES-128 encryption model plus FIPS-197 vectors; a negedge monitor pops and compares.
module tb_aes_inv_iter;
  localparam int LANES = 2;
  localparam int W     = 128 * LANES;

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [W-1:0]   ct_in = '0, pt_out;
  logic [127:0]   key_last = '0;
`ifdef AES_INV_KEY0_OUT_EN
  logic [127:0]   key0_out;
`endif

  aes_inv_iter #(.LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ct_in(ct_in), .key_last(key_last), .out_valid(out_valid),
    .out_ready(out_ready), .pt_out(pt_out)
`ifdef AES_INV_KEY0_OUT_EN
    , .key0_out(key0_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] pt; logic [127:0] k0; } exp_t;
  exp_t         exp_q[$];
  int           acc_hist[$];
  int           errors = 0, checks = 0, cyc = 0, acc_cyc = -1;
  bit           rnd_rdy = 0, ov_prev = 0;
  logic [7:0]   sb [256];
  logic [127:0] rks [11];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // ---------------- reference model: forward AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sb[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rks[0];
    for (int r = 1; r <= 10; r++) begin
      s = sub_shift(s);
      if (r < 10) s = mix(s);
      s = s ^ rks[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver ----------------
  task automatic run_job(input logic [W-1:0] ct, input logic [127:0] kl,
                         input logic [W-1:0] ept, input logic [127:0] ek0, input bit hold);
    exp_t e;
    bit   rdy;
    int   n;
    ct_in = ct; key_last = kl; in_valid = 1;
    e.pt = ept; e.k0 = ek0;
    exp_q.push_back(e);
    n = 0;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk("accept_timeout", 0, 1);
    if (!hold) in_valid = 0;
  endtask

  task automatic model_job(input logic [127:0] k, input bit hold);
    logic [127:0] p0, p1;
    p0 = rnd128(); p1 = rnd128();
    expand(k);
    run_job({enc(p1), enc(p0)}, rks[10], {p1, p0}, k, hold);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", W'(exp_q.size()), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, W'(out_valid), 0);
    chk({tag, "_in_ready"}, W'(in_ready), 1);
    chk({tag, "_pt_out"}, pt_out, '0);
`ifdef AES_INV_KEY0_OUT_EN
    chk({tag, "_key0_out"}, W'(key0_out), 0);
`endif
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        acc_cyc = cyc;
        acc_hist.push_back(cyc);
      end
      if (out_valid && !ov_prev && acc_cyc >= 0)
        chk("latency_edges", W'(cyc - acc_cyc), 11);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", W'(out_valid), 0);
        else begin
          e = exp_q.pop_front();
          chk("pt_out", pt_out, e.pt);
`ifdef AES_INV_KEY0_OUT_EN
          chk("key0_out", W'(key0_out), W'(e.k0));
`endif
        end
      end
    end
    ov_prev = out_valid;
  end

  initial forever begin
    @(posedge clk); #2;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] p1, k;
    int n;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // FIPS-197 App. B in lane 0, model-encrypted random block in lane 1
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expand(k);
    p1 = rnd128();
    run_job({enc(p1), 128'h3925841d02dc09fbdc118597196a0b32},
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
            {p1, 128'h3243f6a8885a308d313198a2e0370734}, k, 0);
    drain();

    // App. C.1 in lane 0, zeros encrypted under the same key in lane 1
    k = 128'h000102030405060708090a0b0c0d0e0f;
    expand(k);
    run_job({enc(128'h0), 128'h69c4e0d86a7b0430d8cdb78070b4c55a},
            128'h13111d7fe3944a17f307a78b4d2b30c5,
            {128'h0, 128'h00112233445566778899aabbccddeeff}, k, 0);
    drain();

    // random jobs with random consumer back-pressure
    rnd_rdy = 1;
    for (int i = 0; i < 8; i++) model_job(rnd128(), 0);
    rnd_rdy = 0;
    out_ready = 1;
    drain();

    // long output stall: data held, input ignored
    out_ready = 0;
    model_job(rnd128(), 0);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("stall_reach_done", W'(out_valid), 1);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      ct_in = {rnd128(), rnd128()};
      @(posedge clk); #1;
      chk("stall_out_valid", W'(out_valid), 1);
      chk("stall_in_ready", W'(in_ready), 0);
      if (exp_q.size() != 0) chk("stall_pt_out", pt_out, exp_q[0].pt);
    end
    in_valid = 0;
    out_ready = 1;
    drain();

    // reset in the 5th RUN cycle discards the job
    model_job(rnd128(), 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 0;
    exp_q.delete();
    @(posedge clk); #1;
    chk_reset("midrun_reset");
    rst_n = 1;
    model_job(rnd128(), 0);
    drain();

    // back-to-back with in_valid held high
    model_job(rnd128(), 1);
    model_job(rnd128(), 0);
    drain();
    if (acc_hist.size() >= 2)
      chk("b2b_accept_gap", W'(acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2]), 12);
    else
      chk("b2b_accept_count", W'(acc_hist.size()), 2);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
